gpio_bank: RTL and testbench

- Parametrised memory-mapped GPIO peripheral; successor to the fixed 16-bit LED and switch pair on the Minisys I/O bus.
- Provides NCH channels, each DATA_W bits wide. Each channel has an LED output register, a synchronised and debounced switch input, change-detect pending bits and a maskable interrupt.
- Sits behind memorio, driven by the CPU's ioread/iowrite strobes.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_bank_if.sv | 22 ++
 rtl/gpio_debounce.sv | 61 ++++++
 rtl/gpio_bank.sv | 112 +++++++++++
 tb/tb_gpio_bank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bank: register map indices and counter sizing.
package gpio_pkg;

  typedef enum logic [1:0] {
    REG_LED  = 2'd0,
    REG_SW   = 2'd1,
    REG_PEND = 2'd2,
    REG_IEN  = 2'd3
  } gpio_reg_e;

  // Bits needed to hold 0 .. cycles-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < cycles) w++;
    return w;
  endfunction

endpackage

// File: rtl/gpio_bank_if.sv
// CPU-side I/O bus seen by the GPIO bank (select, strobes, address, data).
interface gpio_bank_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              iocs;
  logic              iowrite;
  logic              ioread;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output iocs, iowrite, ioread, addr, wdata,
    input  rdata
  );

  modport slave (
    input  iocs, iowrite, ioread, addr, wdata,
    output rdata
  );
endinterface

// File: rtl/gpio_debounce.sv
// One switch channel: two-flop synchroniser, shared debounce counter and stable register.
module gpio_debounce
  import gpio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEB_CYCLES = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] stable_o,
  output logic              chg_o,
  output logic [DATA_W-1:0] diff_o
);

  localparam int unsigned    CNT_W   = cnt_width(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [DATA_W-1:0] s1_q, s1_d;
  logic [DATA_W-1:0] s2_q, s2_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The count runs while sync differs from stable at all; bit changes
  // within that window do not restart it.
  always_comb begin
    s1_d     = sw_in;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    chg_o    = 1'b0;
    diff_o   = '0;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = s2_q;
      cnt_d    = '0;
      chg_o    = 1'b1;
      diff_o   = s2_q ^ stable_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: NCH channels of LED output, debounced switch input,
// W1C change-pending bits and a maskable, registered level interrupt.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NCH        = 2,
  parameter int DEB_CYCLES = 20000,
  parameter int ADDR_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  gpio_bank_if.slave            bus,
  input  logic [NCH*DATA_W-1:0] sw_in,
  output logic [NCH*DATA_W-1:0] led_out,
  output logic                  irq
);

  localparam int CH_W = ADDR_W - 3;

  logic [DATA_W-1:0] led_q  [NCH];
  logic [DATA_W-1:0] led_d  [NCH];
  logic [DATA_W-1:0] ien_q  [NCH];
  logic [DATA_W-1:0] ien_d  [NCH];
  logic [DATA_W-1:0] pend_q [NCH];
  logic [DATA_W-1:0] pend_d [NCH];
  logic              irq_q, irq_d;

  logic [DATA_W-1:0] stable [NCH];
  logic [DATA_W-1:0] diff   [NCH];
  logic [NCH-1:0]    chg;

  logic              wr_en, rd_en, ch_ok;
  logic [CH_W-1:0]   ch_idx;
  gpio_reg_e         reg_idx;
  logic [DATA_W-1:0] rdata_v;
  logic              unused_addr0;

  assign unused_addr0 = bus.addr[0];

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gpio_debounce #(
      .DATA_W     (DATA_W),
      .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
      .clk      (clk),
      .rst      (rst),
      .sw_in    (sw_in[c*DATA_W +: DATA_W]),
      .stable_o (stable[c]),
      .chg_o    (chg[c]),
      .diff_o   (diff[c])
    );
    assign led_out[c*DATA_W +: DATA_W] = led_q[c];
  end

  always_comb begin
    wr_en   = bus.iocs & bus.iowrite;
    rd_en   = bus.iocs & bus.ioread;
    ch_idx  = bus.addr[ADDR_W-1:3];
    reg_idx = gpio_reg_e'(bus.addr[2:1]);
    ch_ok   = (32'(ch_idx) < 32'(NCH));
    irq_d   = 1'b0;
    rdata_v = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      led_d[c]  = led_q[c];
      ien_d[c]  = ien_q[c];
      pend_d[c] = pend_q[c];
      if (wr_en && ch_ok && ch_idx == CH_W'(c)) begin
        case (reg_idx)
          REG_LED:  led_d[c]  = bus.wdata;
          REG_PEND: pend_d[c] = pend_q[c] & ~bus.wdata;
          REG_IEN:  ien_d[c]  = bus.wdata;
          default:  ;
        endcase
      end
      // Applied after the W1C clear so a same-cycle change event wins.
      if (chg[c]) pend_d[c] = pend_d[c] | diff[c];
      irq_d = irq_d | (|(pend_q[c] & ien_q[c]));
      if (rd_en && ch_ok && ch_idx == CH_W'(c)) begin
        case (reg_idx)
          REG_LED:  rdata_v = led_q[c];
          REG_SW:   rdata_v = stable[c];
          REG_PEND: rdata_v = pend_q[c];
          REG_IEN:  rdata_v = ien_q[c];
          default:  rdata_v = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        led_q[c]  <= '0;
        ien_q[c]  <= '0;
        pend_q[c] <= '0;
      end
      irq_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < NCH; c++) begin
        led_q[c]  <= led_d[c];
        ien_q[c]  <= ien_d[c];
        pend_q[c] <= pend_d[c];
      end
      irq_q <= irq_d;
    end
  end

  assign bus.rdata = rdata_v;
  assign irq       = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed and randomized checks of gpio_bank against a cycle-level behavioural model.
module tb_gpio_bank;

  localparam int DATA_W = 16;
  localparam int NCH    = 2;
  localparam int DEB    = 4;
  localparam int ADDR_W = 6;

  logic        clk;
  logic        rst;
  logic [31:0] sw_in;
  logic [31:0] led_out;
  logic        irq;

  gpio_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  gpio_bank #(
    .DATA_W     (DATA_W),
    .NCH        (NCH),
    .DEB_CYCLES (DEB),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: pins pass through a two-deep delay line, then a value
  // is accepted once it has differed from the accepted one for DEB edges running.
  logic [15:0] m_led [NCH];
  logic [15:0] m_ien [NCH];
  logic [15:0] m_pend[NCH];
  logic [15:0] m_stable[NCH];
  int          m_streak[NCH];
  logic [31:0] m_h1, m_h2;
  logic        m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_led[c] = '0; m_ien[c] = '0; m_pend[c] = '0;
      m_stable[c] = '0; m_streak[c] = 0;
    end
    m_h1 = '0; m_h2 = '0; m_irq = 1'b0;
  endtask

  function automatic logic [15:0] model_read(input logic cs, input logic re, input logic [5:0] a);
    int ch;
    ch = int'(a[5:3]);
    if (!(cs && re) || ch >= NCH) return 16'h0;
    case (a[2:1])
      2'd0:    return m_led[ch];
      2'd1:    return m_stable[ch];
      2'd2:    return m_pend[ch];
      default: return m_ien[ch];
    endcase
  endfunction

  task automatic model_edge(input logic cs, input logic we, input logic [5:0] a,
                            input logic [15:0] wd, input logic [31:0] sw);
    logic        any;
    logic [15:0] sync;
    int          ch;
    any = 1'b0;
    for (int c = 0; c < NCH; c++) any = any | (|(m_pend[c] & m_ien[c]));
    ch = int'(a[5:3]);
    if (cs && we && ch < NCH) begin
      case (a[2:1])
        2'd0:    m_led[ch]  = wd;
        2'd2:    m_pend[ch] = m_pend[ch] & ~wd;
        2'd3:    m_ien[ch]  = wd;
        default: ;
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      sync = m_h2[c*16 +: 16];
      if (sync != m_stable[c]) begin
        m_streak[c]++;
        if (m_streak[c] == DEB) begin
          m_pend[c]   = m_pend[c] | (sync ^ m_stable[c]);
          m_stable[c] = sync;
          m_streak[c] = 0;
        end
      end else begin
        m_streak[c] = 0;
      end
    end
    m_h2  = m_h1;
    m_h1  = sw;
    m_irq = any;
  endtask

  // One clock: check combinational read, advance the model, check registered outputs.
  task automatic cycle();
    logic        cs, we, re;
    logic [5:0]  a;
    logic [15:0] wd;
    logic [31:0] sw;
    #1;
    chk("rdata_model", {16'h0, bus.rdata}, {16'h0, model_read(bus.iocs, bus.ioread, bus.addr)});
    cs = bus.iocs; we = bus.iowrite; re = bus.ioread; a = bus.addr; wd = bus.wdata; sw = sw_in;
    @(posedge clk);
    model_edge(cs, we, a, wd, sw);
    #1;
    chk("led_out_model", led_out, {m_led[1], m_led[0]});
    chk("irq_model", {31'h0, irq}, {31'h0, m_irq});
  endtask

  task automatic bus_idle();
    bus.iocs = 1'b0; bus.iowrite = 1'b0; bus.ioread = 1'b0;
    bus.addr = '0; bus.wdata = '0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    bus.iocs = 1'b1; bus.iowrite = 1'b1; bus.ioread = 1'b0;
    bus.addr = a; bus.wdata = d;
    cycle();
    bus_idle();
  endtask

  task automatic rd(input string tag, input logic [5:0] a, input logic [15:0] exp);
    bus.iocs = 1'b1; bus.iowrite = 1'b0; bus.ioread = 1'b1; bus.addr = a;
    #1;
    chk(tag, {16'h0, bus.rdata}, {16'h0, exp});
    cycle();
    bus_idle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int          hold[NCH];
    int          op;
    logic [15:0] nv;

    rst = 1'b0;
    sw_in = '0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_led", led_out, 32'h0);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    rst = 1'b1;

    // LED write on channel 1 then readback
    wr(6'h08, 16'hA5A5);
    chk("led_ch1", led_out, 32'hA5A5_0000);
    rd("rd_led_ch1", 6'h08, 16'hA5A5);

    // Clean step on ch0: SW register updates after 2 + DEB edges
    sw_in = 32'h0000_00F0;
    for (int k = 1; k <= 7; k++) begin
      bus.iocs = 1'b1; bus.ioread = 1'b1; bus.addr = 6'h02;
      #1;
      chk("sw_latency", {16'h0, bus.rdata}, (k - 1 >= 6) ? 32'h00F0 : 32'h0);
      cycle();
    end
    bus_idle();
    rd("pend_step", 6'h04, 16'h00F0);

    // 3-clock glitch is rejected
    sw_in = 32'h0000_00F1;
    idle(3);
    sw_in = 32'h0000_00F0;
    idle(6);
    rd("sw_glitch", 6'h02, 16'h00F0);
    rd("pend_glitch", 6'h04, 16'h00F0);
    chk("irq_glitch", {31'h0, irq}, 32'h0);

    // Interrupt enable and W1C clear
    wr(6'h06, 16'h0010);
    chk("irq_en_delay", {31'h0, irq}, 32'h0);
    cycle();
    chk("irq_set", {31'h0, irq}, 32'h1);
    wr(6'h04, 16'h0010);
    chk("irq_still_high", {31'h0, irq}, 32'h1);
    cycle();
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd("pend_w1c", 6'h04, 16'h00E0);

    // W1C coincident with a new change event on the same bit: set wins
    sw_in = 32'h0000_01F0;
    idle(5);
    wr(6'h04, 16'h0100);
    rd("pend_set_wins", 6'h04, 16'h01E0);

    // Channel 2 does not exist
    wr(6'h10, 16'hFFFF);
    wr(6'h16, 16'hFFFF);
    chk("ch2_led_ignored", led_out, 32'hA5A5_0000);
    rd("ch2_rd_led", 6'h10, 16'h0);
    rd("ch2_rd_sw", 6'h12, 16'h0);

    // Randomized traffic against the model
    for (int c = 0; c < NCH; c++) hold[c] = 1;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          nv = 16'($urandom);
          if ($urandom_range(0, 1) == 0) nv = sw_in[c*16 +: 16] ^ (16'h1 << $urandom_range(0, 15));
          sw_in[c*16 +: 16] = nv;
          hold[c] = int'($urandom_range(1, 8));
        end
      end
      op = int'($urandom_range(0, 3));
      bus.iocs    = (op != 0);
      bus.iowrite = (op == 1 || op == 3);
      bus.ioread  = (op >= 2);
      bus.addr    = 6'($urandom_range(0, 63));
      bus.wdata   = 16'($urandom);
      cycle();
    end
    bus_idle();

    // Asynchronous reset in the middle of a debounce window
    wr(6'h08, 16'h5A5A);
    wr(6'h06, 16'hFFFF);
    wr(6'h0E, 16'hFFFF);
    sw_in = ~sw_in;
    idle(3);
    bus.iocs = 1'b1; bus.ioread = 1'b1; bus.addr = 6'h08;
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_led", led_out, 32'h0);
    chk("async_rst_irq", {31'h0, irq}, 32'h0);
    chk("async_rst_rdata", {16'h0, bus.rdata}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    bus_idle();
    idle(8);
    rd("post_rst_sw0", 6'h02, sw_in[15:0]);
    rd("post_rst_sw1", 6'h0A, sw_in[31:16]);
    rd("post_rst_pend0", 6'h04, sw_in[15:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
